// File: rtl/ram_bit.sv
// Bit-wide RAM with two combinational read ports (A, B) and one synchronous write port (C).
// A synchronous reset clears every cell; reset wins over a simultaneous write.
module ram_bit #(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] port_a_address,
  output logic              port_a_out,
  input  logic [AWIDTH-1:0] port_b_address,
  output logic              port_b_out,
  input  logic [AWIDTH-1:0] port_c_address,
  input  logic              port_c_data,
  input  logic              port_c_we
);

  localparam int DEPTH = 2 ** AWIDTH;

  // Packed vector so that one reset assignment clears every cell on the same edge.
  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (port_c_we) begin
      mem[port_c_address] <= port_c_data;
    end
  end

  // Reads see only registered contents, so a write becomes visible after its edge.
  assign port_a_out = mem[port_a_address];
  assign port_b_out = mem[port_b_address];

endmodule

// File: tb/tb_ram_bit.sv
// Self-checking bench for ram_bit: directed scenarios plus random traffic,
// all compared against an array model of the cells kept in the bench.
module tb_ram_bit;

  localparam int AWIDTH = 8;
  localparam int DEPTH  = 2 ** AWIDTH;

  logic              clk;
  logic              rst;
  logic [AWIDTH-1:0] port_a_address;
  logic              port_a_out;
  logic [AWIDTH-1:0] port_b_address;
  logic              port_b_out;
  logic [AWIDTH-1:0] port_c_address;
  logic              port_c_data;
  logic              port_c_we;

  int tests_run;
  int tests_failed;

  // Reference contents: one bit per cell, updated by the driver after each edge.
  logic model [DEPTH];

  ram_bit #(.AWIDTH(AWIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .port_a_address (port_a_address),
    .port_a_out     (port_a_out),
    .port_b_address (port_b_address),
    .port_b_out     (port_b_out),
    .port_c_address (port_c_address),
    .port_c_data    (port_c_data),
    .port_c_we      (port_c_we)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one edge with the given controls, then mirror its effect in the model.
  task automatic do_edge(input logic r, input logic we, input logic [AWIDTH-1:0] addr,
                         input logic d);
    rst            = r;
    port_c_we      = we;
    port_c_address = addr;
    port_c_data    = d;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) model[i] = 1'b0;
    end else if (we) begin
      model[addr] = d;
    end
    rst       = 1'b0;
    port_c_we = 1'b0;
  endtask

  task automatic set_reads(input logic [AWIDTH-1:0] a, input logic [AWIDTH-1:0] b);
    port_a_address = a;
    port_b_address = b;
    #1;
  endtask

  task automatic test_reset();
    do_edge(1'b1, 1'b0, '0, 1'b0);
    do_edge(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      set_reads(AWIDTH'(i), AWIDTH'(i));
      tests_run++;
      if (port_a_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_a addr=%0d got=%b exp=0", i, port_a_out);
      end
      tests_run++;
      if (port_b_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_b addr=%0d got=%b exp=0", i, port_b_out);
      end
    end
  endtask

  task automatic test_pattern_write();
    // Addresses 1..255 then 0, data alternating starting at 1: odd cells 1, even cells 0.
    for (int k = 0; k < DEPTH; k++) begin
      do_edge(1'b0, 1'b1, AWIDTH'((k + 1) % DEPTH), (k % 2 == 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic exp_bit;
      exp_bit = (i % 2 == 1) ? 1'b1 : 1'b0;
      set_reads(AWIDTH'(i), AWIDTH'(i));
      tests_run++;
      if (port_a_out !== exp_bit || model[i] !== exp_bit) begin
        tests_failed++;
        $display("FAIL pattern addr=%0d got=%b exp=%b", i, port_a_out, exp_bit);
      end
    end
  endtask

  task automatic test_dual_read();
    for (int i = 2; i < DEPTH; i++) begin
      int b;
      b = (DEPTH + 2 - i) % DEPTH;
      set_reads(AWIDTH'(i), AWIDTH'(b));
      tests_run++;
      if (port_a_out !== model[i] || port_b_out !== model[b]) begin
        tests_failed++;
        $display("FAIL dual_read a=%0d b=%0d got=%b%b exp=%b%b", i, b,
                 port_a_out, port_b_out, model[i], model[b]);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_reads(AWIDTH'(i), AWIDTH'(i));
      tests_run++;
      if (port_a_out !== port_b_out || port_a_out !== model[i]) begin
        tests_failed++;
        $display("FAIL same_addr addr=%0d got a=%b b=%b exp=%b", i, port_a_out, port_b_out,
                 model[i]);
      end
    end
  endtask

  task automatic test_write_flip();
    for (int i = 0; i < DEPTH; i++) begin
      int  j;
      logic old_a;
      j = (i + 1) % DEPTH;
      old_a = model[i];
      set_reads(AWIDTH'(i), AWIDTH'(j));
      port_c_we      = 1'b1;
      port_c_address = AWIDTH'(i);
      port_c_data    = ~old_a;
      #1;
      tests_run++;
      if (port_a_out !== old_a) begin
        tests_failed++;
        $display("FAIL no_bypass addr=%0d got=%b exp=%b", i, port_a_out, old_a);
      end
      do_edge(1'b0, 1'b1, AWIDTH'(i), ~old_a);
      tests_run++;
      if (port_a_out !== ~old_a) begin
        tests_failed++;
        $display("FAIL flip_a addr=%0d got=%b exp=%b", i, port_a_out, ~old_a);
      end
      tests_run++;
      if (port_b_out !== model[j]) begin
        tests_failed++;
        $display("FAIL flip_b addr=%0d got=%b exp=%b", j, port_b_out, model[j]);
      end
    end
  endtask

  task automatic test_reset_priority();
    do_edge(1'b1, 1'b0, '0, 1'b0);
    do_edge(1'b1, 1'b1, AWIDTH'(5), 1'b1);
    set_reads(AWIDTH'(5), AWIDTH'(5));
    tests_run++;
    if (port_a_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_over_write addr=5 got=%b exp=0", port_a_out);
    end
    // First edge after reset deasserts must already accept a write.
    do_edge(1'b0, 1'b1, AWIDTH'(5), 1'b1);
    set_reads(AWIDTH'(5), AWIDTH'(4));
    tests_run++;
    if (port_a_out !== 1'b1 || port_b_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_after_rst got a=%b b=%b exp a=1 b=0", port_a_out, port_b_out);
    end
  endtask

  task automatic test_we_low();
    do_edge(1'b0, 1'b0, AWIDTH'(7), 1'b1);
    set_reads(AWIDTH'(7), AWIDTH'(7));
    tests_run++;
    if (port_a_out !== 1'b0 || port_b_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL we_low addr=7 got a=%b b=%b exp=0", port_a_out, port_b_out);
    end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 20; k++) begin
      do_edge(1'b0, 1'b1, AWIDTH'($urandom_range(0, DEPTH - 1)), 1'b1);
    end
    do_edge(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      set_reads(AWIDTH'(i), AWIDTH'(DEPTH - 1 - i));
      tests_run++;
      if (port_a_out !== 1'b0 || port_b_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_reset a=%0d got a=%b b=%b exp=0", i, port_a_out, port_b_out);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic r, we, d;
      logic [AWIDTH-1:0] ca, ra, rb;
      r  = ($urandom_range(0, 39) == 0);
      we = $urandom_range(0, 1);
      d  = $urandom_range(0, 1);
      ca = AWIDTH'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 3) == 0) ? ca : AWIDTH'($urandom_range(0, DEPTH - 1));
      rb = ($urandom_range(0, 3) == 0) ? ra : AWIDTH'($urandom_range(0, DEPTH - 1));
      set_reads(ra, rb);
      tests_run++;
      if (port_a_out !== model[ra] || port_b_out !== model[rb]) begin
        tests_failed++;
        $display("FAIL random n=%0d a=%0d b=%0d got=%b%b exp=%b%b", n, ra, rb,
                 port_a_out, port_b_out, model[ra], model[rb]);
      end
      do_edge(r, we, ca, d);
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    port_a_address = '0;
    port_b_address = '0;
    port_c_address = '0;
    port_c_data    = 1'b0;
    port_c_we      = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 1'b0;

    test_reset();
    test_pattern_write();
    test_dual_read();
    test_write_flip();
    test_reset_priority();
    test_we_low();
    test_mid_reset();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ram_bit.md
RAM_BIT -- requirements
Module: ram_bit

Interface
REQ-001 The block SHALL provide parameter AWIDTH, default 8, setting the address width; memory depth is 2**AWIDTH one-bit cells.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 port_a_address  input  AWIDTH  read port A cell index.
REQ-006 port_a_out  output  1  read port A data.
REQ-007 port_b_address  input  AWIDTH  read port B cell index.
REQ-008 port_b_out  output  1  read port B data.
REQ-009 port_c_address  input  AWIDTH  write port C cell index.
REQ-010 port_c_data  input  1  write port C data bit.
REQ-011 port_c_we  input  1  write enable for port C, active-high.

Function
REQ-012 Storage SHALL be an array of 2**AWIDTH independent 1-bit cells, indices 0 to 2**AWIDTH-1, with no address wrap beyond the AWIDTH bits.
REQ-013 Port A read SHALL be combinational: port_a_out = mem[port_a_address], updating in the same delta as an address change, with zero clock latency.
REQ-014 Port B read SHALL be combinational and fully independent of port A; both ports may address the same or different cells simultaneously with no interaction.
REQ-015 Write SHALL occur on a rising clk edge when port_c_we=1 and rst=0: mem[port_c_address] <= port_c_data; no other cell changes.
REQ-016 With port_c_we=0, no cell SHALL change; port_c_address and port_c_data are don't-care.
REQ-017 When a read port addresses the cell being written, it SHALL return the old value before the edge and the new value immediately after the edge; there is no bypass of data ahead of the edge.
REQ-018 Port A, port B and port C addresses SHALL be allowed to coincide in any combination; writes are always honoured and reads never block writes.
REQ-019 The design SHALL be free of latches, and no output SHALL ever be X after the first reset.

Reset
REQ-020 While rst=1 at a rising clk edge, every cell SHALL be cleared to 0 on that edge.
REQ-021 Reset SHALL take priority over write: a write with port_c_we=1 during reset SHALL be discarded.
REQ-022 After reset, port_a_out and port_b_out SHALL read 0 for every address.
REQ-023 Deasserting reset SHALL require no recovery cycles; a write on the first edge with rst=0 SHALL take effect.
REQ-024 Asserting rst mid-sequence SHALL clear all previously written data on that edge.

Verification
REQ-025 Reset, then sweep port_a_address and port_b_address over 0..255 -> both outputs 0 everywhere.
REQ-026 Write addresses 1,2,...,255,0 in order with data 1,0,1,0,... (one write per edge, we pulsed) -> port A sweep reads mem[odd]=1, mem[even]=0, including mem[0]=0 written last.
REQ-027 Ports A and B read simultaneously, with A ascending 2..255 and B descending from 0 -> each output matches its own cell; with both on the same address 0..255 -> port_a_out == port_b_out on every cycle.
REQ-028 For each cell, write ~port_a_out while port A reads the same cell -> port_a_out flips immediately after the edge, port B (on a different cell) is unchanged.
REQ-029 Write 1 to addr 5 with rst=1 on the same edge -> mem[5]=0; then rst=0 and write 1 to addr 5 -> port_a_out=1 on the next read of addr 5.
REQ-030 Write 1 to addr 7 with port_c_we=0 -> mem[7] is unchanged (0 after reset).
